// File: rtl/cb_wb_deskew_pkg.sv
// Shared encodings for the covariance-BRAM port-B write-back path.
// Direction codes are also consumed by the data mapper and CB controllers.
package cb_wb_deskew_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  localparam logic DIR_NEW_0 = 1'b0;
  localparam logic DIR_NEW_1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/cb_lane_delay.sv
// Fixed-depth valid+data shift register used to pull one skewed RSA lane
// back into row alignment. DEPTH must be at least 1.
module cb_lane_delay #(
  parameter int DEPTH = 1,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic [DW-1:0] d_data,
  output logic          q_valid,
  output logic [DW-1:0] q_data
);

  logic [DEPTH-1:0]         vld_r;
  logic [DEPTH-1:0][DW-1:0] dat_r;

  // shift chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      dat_r <= '0;
    end else begin
      vld_r[0] <= d_valid;
      dat_r[0] <= d_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld_r[k] <= vld_r[k-1];
        dat_r[k] <= dat_r[k-1];
      end
    end
  end

  assign q_valid = vld_r[DEPTH-1];
  assign q_data  = dat_r[DEPTH-1];

endmodule

// File: rtl/cb_wb_deskew.sv
// CB port-B write-back sequencer: deskews RSA C-output lanes into rows,
// drives the mapper data/select one cycle ahead of the port-B address/enables.
module cb_wb_deskew
  import cb_wb_deskew_pkg::*;
#(
  parameter int X       = 4,
  parameter int L       = 4,
  parameter int RSA_DW  = 16,
  parameter int ROW_LEN = 10,
  parameter int CB_AW   = 10
) (
  input  logic                           clk,
  input  logic                           sys_rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_dir,
  input  logic                           cmd_l_k_0,
  input  logic [CB_AW-1:0]               cmd_base_addr,
  input  logic [$clog2(ROW_LEN+1)-1:0]   cmd_rows,
  input  logic [X-1:0]                   rsa_valid,
  input  logic [X*RSA_DW-1:0]            rsa_data,
  output logic [X*RSA_DW-1:0]            C_CB_dinb,
  output logic [1:0]                     CB_dinb_sel,
  output logic                           l_k_0,
  output logic                           CB_enb,
  output logic                           CB_web,
  output logic [CB_AW-1:0]               CB_addrb,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int RW = $clog2(ROW_LEN + 1);

  if (X != L) begin : g_lane_check
    $error("cb_wb_deskew: RSA lane count X must equal CB word lanes L");
  end

  wb_state_e                  state_r, next_s;
  logic [1:0]                 dir_r;
  logic                       lk_r;
  logic [CB_AW-1:0]           base_r;
  logic [RW-1:0]              rows_r, row_cnt_r;
  logic                       accept_s, emit_s, last_s, skew_err_s, stray_s;
  logic [X-1:0]               dly_valid_s;
  logic [X-1:0][RSA_DW-1:0]   dly_data_s;
  logic [X*RSA_DW-1:0]        row_s;
  logic [CB_AW-1:0]           row_addr_s;
  logic                       emit_d_r, done_d_r;
  logic [CB_AW-1:0]           addr_d_r;

  // Lane i waits X-1-i cycles; the most-skewed lane is already aligned.
  for (genvar i = 0; i < X - 1; i++) begin : g_lane
    cb_lane_delay #(.DEPTH(X - 1 - i), .DW(RSA_DW)) u_dly (
      .clk     (clk),
      .rst_n   (sys_rst_n),
      .d_valid (rsa_valid[i]),
      .d_data  (rsa_data[i*RSA_DW +: RSA_DW]),
      .q_valid (dly_valid_s[i]),
      .q_data  (dly_data_s[i])
    );
  end
  assign dly_valid_s[X-1] = rsa_valid[X-1];
  assign dly_data_s[X-1]  = rsa_data[(X-1)*RSA_DW +: RSA_DW];

  // row assembly; lanes disagreeing with the reference lane are zeroed
  always_comb begin
    row_s      = '0;
    skew_err_s = 1'b0;
    for (int i = 0; i < X; i++) begin
      if (dly_valid_s[i]) row_s[i*RSA_DW +: RSA_DW] = dly_data_s[i];
      else                row_s[i*RSA_DW +: RSA_DW] = '0;
      if (dly_valid_s[i] != dly_valid_s[X-1]) skew_err_s = 1'b1;
      else                                    skew_err_s = skew_err_s;
    end
  end

  assign emit_s     = dly_valid_s[X-1] && (state_r == ST_RUN) && (row_cnt_r < rows_r);
  assign last_s     = emit_s && ((row_cnt_r + RW'(1)) == rows_r);
  assign stray_s    = dly_valid_s[X-1] && !emit_s;
  assign row_addr_s = (dir_r == DIR_NEG) ? (base_r - CB_AW'(row_cnt_r))
                                         : (base_r + CB_AW'(row_cnt_r));

  // next-state logic
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_s = 1'b1;
          if ((cmd_rows == '0) || (cmd_dir == DIR_IDLE)) next_s = ST_DONE;
          else                                           next_s = ST_RUN;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) next_s = ST_DONE;
        else        next_s = ST_RUN;
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // state, command latch, row counter and sticky error
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      dir_r     <= DIR_IDLE;
      lk_r      <= 1'b0;
      base_r    <= '0;
      rows_r    <= '0;
      row_cnt_r <= '0;
    end else begin
      state_r   <= next_s;
      cmd_ready <= (next_s == ST_IDLE);
      busy      <= (next_s == ST_RUN);
      if (accept_s) begin
        dir_r     <= cmd_dir;
        lk_r      <= cmd_l_k_0;
        base_r    <= cmd_base_addr;
        rows_r    <= cmd_rows;
        row_cnt_r <= '0;
        err       <= 1'b0;
      end else begin
        if (emit_s) row_cnt_r <= row_cnt_r + RW'(1);
        if (skew_err_s || stray_s) err <= 1'b1;
      end
    end
  end

  // Data stage feeds the mapper; address/enable stage trails it by one
  // cycle to line up with the mapper's output register. done follows the
  // same two-stage path so it can never overtake the last write.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      C_CB_dinb   <= '0;
      CB_dinb_sel <= DIR_IDLE;
      l_k_0       <= 1'b0;
      emit_d_r    <= 1'b0;
      addr_d_r    <= '0;
      done_d_r    <= 1'b0;
      CB_enb      <= 1'b0;
      CB_web      <= 1'b0;
      CB_addrb    <= '0;
      done        <= 1'b0;
    end else begin
      if (emit_s) begin
        C_CB_dinb   <= row_s;
        CB_dinb_sel <= dir_r;
        l_k_0       <= lk_r;
        addr_d_r    <= row_addr_s;
      end else begin
        C_CB_dinb   <= '0;
        CB_dinb_sel <= DIR_IDLE;
        l_k_0       <= 1'b0;
        addr_d_r    <= '0;
      end
      emit_d_r <= emit_s;
      done_d_r <= (state_r == ST_DONE);
      CB_enb   <= emit_d_r;
      CB_web   <= emit_d_r;
      CB_addrb <= emit_d_r ? addr_d_r : '0;
      done     <= done_d_r;
    end
  end

endmodule

// File: tb/tb_cb_wb_deskew.sv
// Scoreboard bench for cb_wb_deskew: expected rows/addresses are queued when
// stimulus is driven and compared as the DUT emits them.
module tb_cb_wb_deskew;
  import cb_wb_deskew_pkg::*;

  localparam int X = 4, RSA_DW = 16, CB_AW = 10, RW = 4;

  logic                clk = 1'b0;
  logic                sys_rst_n = 1'b0;
  logic                cmd_valid = 1'b0, cmd_ready, cmd_l_k_0 = 1'b0;
  logic [1:0]          cmd_dir = 2'b00;
  logic [CB_AW-1:0]    cmd_base_addr = '0;
  logic [RW-1:0]       cmd_rows = '0;
  logic [X-1:0]        rsa_valid = '0;
  logic [X*RSA_DW-1:0] rsa_data = '0;
  logic [X*RSA_DW-1:0] C_CB_dinb;
  logic [1:0]          CB_dinb_sel;
  logic                l_k_0, CB_enb, CB_web, busy, done, err;
  logic [CB_AW-1:0]    CB_addrb;

  cb_wb_deskew dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_l_k_0(cmd_l_k_0), .cmd_base_addr(cmd_base_addr),
    .cmd_rows(cmd_rows), .rsa_valid(rsa_valid), .rsa_data(rsa_data),
    .C_CB_dinb(C_CB_dinb), .CB_dinb_sel(CB_dinb_sel), .l_k_0(l_k_0),
    .CB_enb(CB_enb), .CB_web(CB_web), .CB_addrb(CB_addrb),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  sel;
    logic        lk;
  } row_exp_t;

  row_exp_t         exp_row_q[$];
  logic [CB_AW-1:0] exp_addr_q[$];
  row_exp_t         mon_row;
  logic [CB_AW-1:0] mon_addr;
  logic [63:0]      feed_rows[4];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, enb_cnt = 0;
  int done_cyc = 0, last_web_cyc = 0, last_row_cyc = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // output monitor: pops the scoreboard whenever the DUT emits something
  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (CB_dinb_sel != 2'b00 || C_CB_dinb != '0) begin
        last_row_cyc = cyc;
        check_val("row_expected", 64'(exp_row_q.size() != 0), 64'd1);
        if (exp_row_q.size() != 0) begin
          mon_row = exp_row_q.pop_front();
          check_val("row_data", C_CB_dinb, mon_row.data);
          check_val("row_sel", 64'(CB_dinb_sel), 64'(mon_row.sel));
          check_val("row_lk", 64'(l_k_0), 64'(mon_row.lk));
        end
      end
      if (CB_enb || CB_web) begin
        enb_cnt++;
        last_web_cyc = cyc;
        check_val("addr_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) begin
          mon_addr = exp_addr_q.pop_front();
          check_val("addrb", 64'(CB_addrb), 64'(mon_addr));
          check_val("web", 64'(CB_web), 64'd1);
          check_val("enb", 64'(CB_enb), 64'd1);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic issue_cmd(input logic [1:0] dir, input logic lk,
                           input logic [CB_AW-1:0] base, input int n);
    int w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check_val("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_l_k_0 = lk;
    cmd_base_addr = base; cmd_rows = RW'(n);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_l_k_0 = 1'b0;
  endtask

  task automatic feed(input int n, input int late);
    for (int c = 0; c < n + X + 1; c++) begin
      for (int i = 0; i < X; i++) begin
        int r = c - i - ((i == late) ? 1 : 0);
        if (r >= 0 && r < n) begin
          rsa_valid[i] = 1'b1;
          rsa_data[i*RSA_DW +: RSA_DW] = feed_rows[r][i*RSA_DW +: RSA_DW];
        end else begin
          rsa_valid[i] = 1'b0;
          rsa_data[i*RSA_DW +: RSA_DW] = 16'($urandom_range(0, 65535));
        end
      end
      @(posedge clk); #1;
    end
    rsa_valid = '0;
  endtask

  task automatic wait_done(input int d0);
    int w = 0;
    while (done_cnt == d0 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    check_val("done_seen", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic push_exp(input logic [1:0] dir, input logic lk,
                          input logic [CB_AW-1:0] base, input int n, input int late);
    logic [63:0] m;
    for (int r = 0; r < n; r++) begin
      m = feed_rows[r];
      if (late >= 0) m[late*RSA_DW +: RSA_DW] = '0;
      exp_row_q.push_back('{data: m, sel: dir, lk: lk});
      if (dir == DIR_NEG) exp_addr_q.push_back(base - CB_AW'(r));
      else                exp_addr_q.push_back(base + CB_AW'(r));
    end
  endtask

  task automatic run_cmd(input logic [1:0] dir, input logic lk, input logic [CB_AW-1:0] base,
                         input int n, input int late, input logic exp_err);
    int d0, fs;
    push_exp(dir, lk, base, n, late);
    d0 = done_cnt;
    issue_cmd(dir, lk, base, n);
    check_val("err_clear_on_accept", 64'(err), 64'd0);
    check_val("busy_in_run", 64'(busy), 64'd1);
    check_val("ready_low_in_run", 64'(cmd_ready), 64'd0);
    // an offer while busy must be ignored
    cmd_valid = 1'b1; cmd_dir = DIR_POS; cmd_base_addr = 10'h155; cmd_rows = 4'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_dir = 2'b00;
    fs = cyc;
    feed(n, late);
    wait_done(d0);
    check_val("dinb_latency", 64'(last_row_cyc - fs), 64'(n - 1 + X));
    check_val("web_latency", 64'(last_web_cyc - fs), 64'(n + X));
    check_val("done_after_web", 64'(done_cyc - last_web_cyc), 64'd1);
    check_val("rows_drained", 64'(exp_row_q.size()), 64'd0);
    check_val("addrs_drained", 64'(exp_addr_q.size()), 64'd0);
    check_val("err_final", 64'(err), 64'(exp_err));
  endtask

  task automatic zero_cmd(input logic [1:0] dir, input int n);
    int d0, e0, acc;
    d0 = done_cnt; e0 = enb_cnt;
    issue_cmd(dir, 1'b0, 10'h0AA, n);
    acc = cyc;
    wait_done(d0);
    check_val("zero_done_delay", 64'(done_cyc - acc), 64'd2);
    check_val("zero_no_enb", 64'(enb_cnt - e0), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_dinb"}, C_CB_dinb, 64'd0);
    check_val({tag, "_sel"}, 64'(CB_dinb_sel), 64'd0);
    check_val({tag, "_enb_web"}, 64'({CB_enb, CB_web}), 64'd0);
    check_val({tag, "_addrb"}, 64'(CB_addrb), 64'd0);
    check_val({tag, "_flags"}, 64'({l_k_0, busy, done, err, cmd_ready}), 64'd0);
  endtask

  initial begin
    int d0, e0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    sys_rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("ready_after_reset", 64'(cmd_ready), 64'd1);

    feed_rows[0] = 64'h0004_0003_0002_0001;
    feed_rows[1] = 64'h0008_0007_0006_0005;
    feed_rows[2] = 64'h000C_000B_000A_0009;
    run_cmd(DIR_POS, 1'b0, 10'h010, 3, -1, 1'b0);

    feed_rows[0] = 64'hD00D_C00C_B00B_A00A;
    run_cmd(DIR_POS, 1'b0, 10'h020, 1, 2, 1'b1);

    feed_rows[0] = 64'h1111_2222_3333_4444;
    feed_rows[1] = 64'h5555_6666_7777_8888;
    run_cmd(DIR_NEG, 1'b0, 10'h005, 2, -1, 1'b0);

    feed_rows[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    feed_rows[1] = 64'h0F0F_F0F0_1234_5678;
    run_cmd(DIR_NEW, DIR_NEW_1, 10'h3FF, 2, -1, 1'b0);

    zero_cmd(DIR_POS, 0);
    zero_cmd(DIR_IDLE, 3);

    // abandon a 3-row command after its first write
    feed_rows[0] = 64'h0BAD_0CAF_0FEE_0DAD;
    push_exp(DIR_POS, 1'b0, 10'h040, 1, -1);
    d0 = done_cnt; e0 = enb_cnt;
    issue_cmd(DIR_POS, 1'b0, 10'h040, 3);
    feed(1, -1);
    check_val("pre_reset_write", 64'(enb_cnt - e0), 64'd1);
    check_val("pre_reset_busy", 64'(busy), 64'd1);
    @(negedge clk); #2;
    sys_rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    repeat (2) @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("no_done_after_reset", 64'(done_cnt - d0), 64'd0);

    feed_rows[0] = 64'h0102_0304_0506_0708;
    run_cmd(DIR_POS, 1'b0, 10'h100, 1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
